// File: rtl/pixel_req_server.sv
// Source end of the get3 pixel-request conduit: each reqclk rising edge fetches the next raster pixel.
// Optional PIX_TEST_PATTERN_EN adds test_en, replacing frame-store reads with 8 vertical colour bars.
module pixel_req_server #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
`ifdef PIX_TEST_PATTERN_EN
    input  logic                test_en,
`endif
    input  logic                reqclk,
    input  logic                frame_sw0,
    input  logic                frame_sw1,
    output logic                mem_rd,
    output logic [ADDR_W+1:0]   mem_addr,
    input  logic [23:0]         mem_rdata,
    output logic [7:0]          pix_r,
    output logic [7:0]          pix_g,
    output logic [7:0]          pix_b,
    output logic [10:0]         pix_x,
    output logic [10:0]         pix_y,
    output logic                pix_sw,
    output logic [7:0]          ovf_cnt
);

    localparam int unsigned COORD_W = 11;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned RGB_W   = 24;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               req_q;
    logic               pending_q, pending_d;
    logic [COORD_W-1:0] x_q,       x_d;
    logic [COORD_W-1:0] y_q,       y_d;
    logic [ADDR_W-1:0]  offset_q,  offset_d;
    logic [1:0]         bank_q,    bank_d;
    logic [RGB_W-1:0]   rdata_q,   rdata_d;
    logic               mem_rd_q,  mem_rd_d;
    logic [ADDR_W+1:0]  mem_addr_q, mem_addr_d;
    logic [RGB_W-1:0]   pix_rgb_q, pix_rgb_d;
    logic [COORD_W-1:0] pix_x_q,   pix_x_d;
    logic [COORD_W-1:0] pix_y_q,   pix_y_d;
    logic               pix_sw_q,  pix_sw_d;
    logic [7:0]         ovf_q,     ovf_d;
    logic               req_c;
    logic               tp_c;
    logic [RGB_W-1:0]   present_rgb_c;

`ifdef PIX_TEST_PATTERN_EN
    logic               tp_q, tp_d;
    logic [2:0]         bar_c;

    assign tp_c  = test_en;
    assign bar_c = 3'((32'(x_q) * 32'd8) / H_ACTIVE);
    assign present_rgb_c = tp_q ? {{8{bar_c[2]}}, {8{bar_c[1]}}, {8{bar_c[0]}}} : rdata_q;
`else
    assign tp_c          = 1'b0;
    assign present_rgb_c = rdata_q;
`endif

    assign req_c = reqclk & ~req_q;

    // Next-state, pending/overflow bookkeeping and registered output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        x_d        = x_q;
        y_d        = y_q;
        offset_d   = offset_q;
        bank_d     = bank_q;
        rdata_d    = rdata_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        pix_rgb_d  = pix_rgb_q;
        pix_x_d    = pix_x_q;
        pix_y_d    = pix_y_q;
        pix_sw_d   = pix_sw_q;
        ovf_d      = ovf_q;
`ifdef PIX_TEST_PATTERN_EN
        tp_d       = tp_q;
`endif

        // A new edge while busy is queued once; any further edge is counted as dropped
        if (req_c && state_q != ST_IDLE) begin
            if (pending_q) begin
                if (ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
            end else begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (req_c || pending_q) begin
                    state_d    = ST_FETCH;
                    pending_d  = 1'b0;
                    cnt_d      = '0;
                    mem_rd_d   = ~tp_c;
                    mem_addr_d = {bank_q, offset_q};
                    pix_sw_d   = 1'b0;
`ifdef PIX_TEST_PATTERN_EN
                    tp_d       = tp_c;
`endif
                end
            end
            ST_FETCH: begin
                if (cnt_q == CNT_W'(RD_LAT)) begin
                    rdata_d = mem_rdata;
                    state_d = ST_PRESENT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESENT: begin
                pix_rgb_d = present_rgb_c;
                pix_x_d   = x_q;
                pix_y_d   = y_q;
                pix_sw_d  = 1'b1;
                state_d   = ST_IDLE;
                // Bank select is only re-sampled when the frame wraps
                if (x_q == COORD_W'(H_ACTIVE - 1)) begin
                    x_d = '0;
                    if (y_q == COORD_W'(V_ACTIVE - 1)) begin
                        y_d      = '0;
                        offset_d = '0;
                        bank_d   = {frame_sw1, frame_sw0};
                    end else begin
                        y_d      = y_q + COORD_W'(1);
                        offset_d = offset_q + ADDR_W'(1);
                    end
                end else begin
                    x_d      = x_q + COORD_W'(1);
                    offset_d = offset_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            pending_q  <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            offset_q   <= '0;
            bank_q     <= '0;
            rdata_q    <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            pix_rgb_q  <= '0;
            pix_x_q    <= '0;
            pix_y_q    <= '0;
            pix_sw_q   <= 1'b0;
            ovf_q      <= '0;
`ifdef PIX_TEST_PATTERN_EN
            tp_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= reqclk;
            pending_q  <= pending_d;
            x_q        <= x_d;
            y_q        <= y_d;
            offset_q   <= offset_d;
            bank_q     <= bank_d;
            rdata_q    <= rdata_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            pix_rgb_q  <= pix_rgb_d;
            pix_x_q    <= pix_x_d;
            pix_y_q    <= pix_y_d;
            pix_sw_q   <= pix_sw_d;
            ovf_q      <= ovf_d;
`ifdef PIX_TEST_PATTERN_EN
            tp_q       <= tp_d;
`endif
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign pix_r    = pix_rgb_q[23:16];
    assign pix_g    = pix_rgb_q[15:8];
    assign pix_b    = pix_rgb_q[7:0];
    assign pix_x    = pix_x_q;
    assign pix_y    = pix_y_q;
    assign pix_sw   = pix_sw_q;
    assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_pixel_req_server.sv
// Directed bench for pixel_req_server; a short 640x8 frame keeps the frame-wrap run small.
module tb_pixel_req_server;

    localparam int unsigned H   = 640;
    localparam int unsigned V   = 8;
    localparam int unsigned AW  = 19;
    localparam int unsigned LAT = 2;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n;
    logic          reqclk;
    logic          frame_sw0;
    logic          frame_sw1;
    logic          mem_rd;
    logic [AW+1:0] mem_addr;
    logic [23:0]   mem_rdata;
    logic [7:0]    pix_r, pix_g, pix_b;
    logic [10:0]   pix_x, pix_y;
    logic          pix_sw;
    logic [7:0]    ovf_cnt;
`ifdef PIX_TEST_PATTERN_EN
    logic          test_en = 1'b0;
`endif

    always #5 clk_clk = ~clk_clk;

    pixel_req_server #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .RD_LAT(LAT)) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
`ifdef PIX_TEST_PATTERN_EN
        .test_en      (test_en),
`endif
        .reqclk       (reqclk),
        .frame_sw0    (frame_sw0),
        .frame_sw1    (frame_sw1),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .pix_r        (pix_r),
        .pix_g        (pix_g),
        .pix_b        (pix_b),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_sw       (pix_sw),
        .ovf_cnt      (ovf_cnt)
    );

    function automatic logic [23:0] mem_f(input logic [AW+1:0] a);
        return 24'(a) ^ 24'h123456;
    endfunction

    // Frame-store model: data for a strobed address appears LAT cycles later, filler otherwise
    logic [23:0] pipe_q [LAT];
    always @(posedge clk_clk) begin
        pipe_q[0] <= mem_rd ? mem_f(mem_addr) : 24'hA5A5A5;
        for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign mem_rdata = pipe_q[LAT-1];

    int rd_seen = 0;
    always @(posedge clk_clk) if (mem_rd) rd_seen = rd_seen + 1;

    int checks = 0;
    int errors = 0;
    int svc    = 0;
    logic          rd1, sw1, sw4;
    logic [AW+1:0] addr_seen;
    logic [AW+1:0] eaddr;
    int            rd_before;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_clk);
        #1;
    endtask

    // One request edge; returns in the first cycle pix_sw should be 1 (N+5)
    task automatic req_one;
        reqclk = 1'b1;
        tick;
        rd1       = mem_rd;
        addr_seen = mem_addr;
        sw1       = pix_sw;
        reqclk    = 1'b0;
        tick; tick; tick;
        sw4 = pix_sw;
        tick;
        svc++;
    endtask

    // Three edges two cycles apart: one served, one queued, one dropped
    task automatic burst;
        reqclk = 1'b1; tick;
        reqclk = 1'b0; tick;
        reqclk = 1'b1; tick;
        reqclk = 1'b0; tick;
        reqclk = 1'b1; tick;
        reqclk = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        svc += 2;
    endtask

    initial begin
        reset_reset_n = 1'b0;
        reqclk        = 1'b0;
        frame_sw0     = 1'b0;
        frame_sw1     = 1'b0;
        tick; tick;
        check("reset_pix", 64'({pix_r, pix_g, pix_b, pix_x, pix_y, pix_sw}), 64'd0);
        check("reset_mem_ovf", 64'({mem_rd, mem_addr, ovf_cnt}), 64'd0);
        reset_reset_n = 1'b1;
        tick;

        // First pixel: latency and data path
        req_one;
        check("first_mem_rd", 64'(rd1), 64'd1);
        check("first_addr", 64'(addr_seen), 64'd0);
        check("first_sw_n1", 64'(sw1), 64'd0);
        check("first_sw_n4", 64'(sw4), 64'd0);
        check("first_sw_n5", 64'(pix_sw), 64'd1);
        check("first_rgb", 64'({pix_r, pix_g, pix_b}), 64'h123456);
        check("first_xy", 64'({pix_x, pix_y}), 64'd0);

        // Rest of the frame; bank select changes mid-frame and must be ignored
        for (int k = 1; k < int'(H * V); k++) begin
            if (k == 100) begin
                frame_sw1 = 1'b1;
                frame_sw0 = 1'b0;
            end
            req_one;
            eaddr = {2'b00, AW'(k)};
            check("frame_addr", 64'({rd1, sw4, pix_sw, addr_seen}), 64'({1'b1, 1'b0, 1'b1, eaddr}));
            check("frame_pix", 64'({pix_x, pix_y, pix_r, pix_g, pix_b}),
                  64'({11'(k % int'(H)), 11'(k / int'(H)), mem_f(eaddr)}));
            if (k == int'(6 * H) - 1) check("line_end_xy", 64'({pix_x, pix_y}), 64'({11'd639, 11'd5}));
            if (k == int'(6 * H))
                check("line_wrap", 64'({pix_x, pix_y, addr_seen}), 64'({11'd0, 11'd6, 21'd3840}));
        end

        // First pixel of the next frame comes from bank 2
        req_one;
        check("wrap_addr", 64'(addr_seen), 64'({2'b10, 19'd0}));
        check("wrap_xy", 64'({pix_x, pix_y}), 64'd0);
        check("wrap_rgb", 64'({pix_r, pix_g, pix_b}), 64'h023456);

        // Overflow: one burst, then saturation
        rd_before = rd_seen;
        burst;
        check("burst_ovf", 64'(ovf_cnt), 64'd1);
        check("burst_rd", 64'(rd_seen - rd_before), 64'd2);
        check("burst_pix", 64'({pix_sw, pix_x, pix_y, pix_r, pix_g, pix_b}),
              64'({1'b1, 11'd2, 11'd0, 24'h023454}));
        for (int b = 0; b < 299; b++) burst;
        check("ovf_sat", 64'(ovf_cnt), 64'd255);
        check("burst_last_x", 64'({pix_x, pix_y}), 64'({11'd600, 11'd0}));

        // Reset during FETCH cycle 1
        reqclk = 1'b1; tick;
        reqclk = 1'b0; tick;
        svc++;
        reset_reset_n = 1'b0;
        #1;
        check("midrst_pix", 64'({pix_r, pix_g, pix_b, pix_x, pix_y, pix_sw}), 64'd0);
        check("midrst_mem_ovf", 64'({mem_rd, mem_addr, ovf_cnt}), 64'd0);
        tick; tick;
        reset_reset_n = 1'b1;
        tick; tick; tick; tick;
        req_one;
        check("postrst_addr", 64'({rd1, addr_seen}), 64'({1'b1, 21'd0}));
        check("postrst_pix", 64'({pix_sw, pix_x, pix_y, pix_r, pix_g, pix_b}),
              64'({1'b1, 11'd0, 11'd0, 24'h123456}));

        check("mem_rd_total", 64'(rd_seen), 64'(svc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
